// File: rtl/mul_pipe_w_yjy.sv
// rtl/mul_pipe_w_yjy.sv - four-stage pipelined WIDTHxWIDTH multiplier with handshake, tag and in-flight count
//
// Purpose:
//   Full 2*WIDTH-bit product of two packed WIDTH-bit operands, built from
//   unsigned 8x8 partial products across four register stages:
//     S1  operand/mode/tag capture
//     S2  (WIDTH/8)^2 partial products
//     S3  partial products folded into two accumulators (even / odd byte columns)
//     S4  final add, optional signed correction of the high half, output registers
//   A single global stall (o_valid && !o_ready) freezes every stage.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   i_msg       packed operands, a = i_msg[WIDTH-1:0], b = i_msg[2*WIDTH-1:WIDTH]
//   i_signed    1 = two's-complement product (only honoured with MUL_PIPE_W_SIGNED_EN)
//   i_tag       caller tag carried with the beat
//   i_valid     operand beat present
//   i_ready     block accepts a beat this cycle
//   o_valid     result beat present
//   o_ready     consumer accepts result
//   o_lo        product bits [WIDTH-1:0]
//   o_hi        product bits [2*WIDTH-1:WIDTH]
//   o_tag       tag of the result beat
//   o_inflight  number of valid stages S1..S4
//
// Configuration macro: MUL_PIPE_W_SIGNED_EN (defined = signed mode supported,
//   undefined = i_signed ignored, unsigned products only).

module mul_pipe_w_yjy #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [2*WIDTH-1:0] i_msg,
    input  logic               i_signed,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_valid,
    output logic               i_ready,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [WIDTH-1:0]   o_lo,
    output logic [WIDTH-1:0]   o_hi,
    output logic [TAG_W-1:0]   o_tag,
    output logic [2:0]         o_inflight
);

    localparam int NB = WIDTH / 8;
    localparam int PW = 2 * WIDTH;

    // ------------------------------------------------------------------
    // Global flow control
    // ------------------------------------------------------------------
    logic stall;
    logic adv;

    assign stall   = o_valid && !o_ready;
    assign adv     = !stall;
    assign i_ready = adv;

    // ------------------------------------------------------------------
    // Stage valid bits and output registers (the only reset state)
    // ------------------------------------------------------------------
    logic       s1_v;
    logic       s2_v;
    logic       s3_v;
    logic [2:0] inflight_next;

    // Count of valid bits as they will be after this edge, so o_inflight
    // always equals the popcount of the registered valid bits.
    assign inflight_next = {2'b00, i_valid} + {2'b00, s1_v} + {2'b00, s2_v} + {2'b00, s3_v};

    // S4 combinational result
    logic [WIDTH-1:0] s4_lo;
    logic [WIDTH-1:0] s4_hi;
    logic [TAG_W-1:0] s3_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s3_v       <= 1'b0;
            o_valid    <= 1'b0;
            o_inflight <= 3'd0;
            o_lo       <= '0;
            o_hi       <= '0;
            o_tag      <= '0;
        end else if (adv) begin
            s1_v       <= i_valid;
            s2_v       <= s1_v;
            s3_v       <= s2_v;
            o_valid    <= s3_v;
            o_inflight <= inflight_next;
            // Output data only changes when a real beat arrives, so the last
            // result stays visible after o_valid falls.
            if (s3_v) begin
                o_lo  <= s4_lo;
                o_hi  <= s4_hi;
                o_tag <= s3_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: operand capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (adv && i_valid) begin
            s1_a   <= i_msg[WIDTH-1:0];
            s1_b   <= i_msg[2*WIDTH-1:WIDTH];
            s1_tag <= i_tag;
        end
    end

`ifdef MUL_PIPE_W_SIGNED_EN
    // Mode plus the raw operands travel to S4 for the high-half correction.
    logic             s1_sgn;
    logic             s2_sgn;
    logic             s3_sgn;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH-1:0] s3_a;
    logic [WIDTH-1:0] s3_b;

    always_ff @(posedge clk) begin
        if (adv && i_valid) begin
            s1_sgn <= i_signed;
        end
        if (adv && s1_v) begin
            s2_sgn <= s1_sgn;
            s2_a   <= s1_a;
            s2_b   <= s1_b;
        end
        if (adv && s2_v) begin
            s3_sgn <= s2_sgn;
            s3_a   <= s2_a;
            s3_b   <= s2_b;
        end
    end
`else
    // Port kept for interface compatibility; its value is never used.
    logic unused_signed;
    assign unused_signed = i_signed;
`endif

    // ------------------------------------------------------------------
    // S2: unsigned 8x8 partial products, pp[i][j] = a.byte[i] * b.byte[j]
    // ------------------------------------------------------------------
    logic [15:0]      s2_pp [NB][NB];
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk) begin
        if (adv && s1_v) begin
            for (int i = 0; i < NB; i++) begin
                for (int j = 0; j < NB; j++) begin
                    s2_pp[i][j] <= 16'(s1_a[8*i +: 8]) * 16'(s1_b[8*j +: 8]);
                end
            end
            s2_tag <= s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // S3: fold partial products into two accumulators. Products landing at
    // an even byte offset go to one, odd offsets to the other, so that
    // neighbouring 16-bit terms in the same accumulator never overlap by
    // more than one byte and the adder trees stay shallow. Neither sum can
    // exceed the full product, so PW bits hold them without overflow.
    // ------------------------------------------------------------------
    logic [PW-1:0] sum_even;
    logic [PW-1:0] sum_odd;
    logic [PW-1:0] pp_term;

    always_comb begin
        sum_even = '0;
        sum_odd  = '0;
        pp_term  = '0;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
                pp_term = PW'(s2_pp[i][j]) << (8 * (i + j));
                if (((i + j) % 2) == 0) begin
                    sum_even = sum_even + pp_term;
                end else begin
                    sum_odd = sum_odd + pp_term;
                end
            end
        end
    end

    logic [PW-1:0] s3_even;
    logic [PW-1:0] s3_odd;

    always_ff @(posedge clk) begin
        if (adv && s2_v) begin
            s3_even <= sum_even;
            s3_odd  <= sum_odd;
            s3_tag  <= s2_tag;
        end
    end

    // ------------------------------------------------------------------
    // S4: final add and signed correction. For two's-complement operands
    // the low half is unchanged; the high half loses b when a is negative
    // and a when b is negative (mod 2^WIDTH).
    // ------------------------------------------------------------------
    logic [PW-1:0] full_u;

    assign full_u = s3_even + s3_odd;
    assign s4_lo  = full_u[WIDTH-1:0];

`ifdef MUL_PIPE_W_SIGNED_EN
    logic [WIDTH-1:0] corr_a;
    logic [WIDTH-1:0] corr_b;

    assign corr_a = (s3_sgn && s3_a[WIDTH-1]) ? s3_b : '0;
    assign corr_b = (s3_sgn && s3_b[WIDTH-1]) ? s3_a : '0;
    assign s4_hi  = full_u[PW-1:WIDTH] - corr_a - corr_b;
`else
    assign s4_hi  = full_u[PW-1:WIDTH];
`endif

endmodule

// File: tb/tb_mul_pipe_w_yjy.sv
// tb/tb_mul_pipe_w_yjy.sv - directed self-checking bench for mul_pipe_w_yjy (WIDTH=32, TAG_W=4)

module tb_mul_pipe_w_yjy;

    logic        clk;
    logic        rstn;
    logic [63:0] i_msg;
    logic        i_signed;
    logic [3:0]  i_tag;
    logic        i_valid;
    logic        i_ready;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_lo;
    logic [31:0] o_hi;
    logic [3:0]  o_tag;
    logic [2:0]  o_inflight;

    int checks;
    int errors;

    mul_pipe_w_yjy #(.WIDTH(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_msg      (i_msg),
        .i_signed   (i_signed),
        .i_tag      (i_tag),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_lo       (o_lo),
        .o_hi       (o_hi),
        .o_tag      (o_tag),
        .o_inflight (o_inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand tables: back-to-back stream (tags 0..7), backpressure (tags 8..13)
    logic [31:0] st_a [8] = '{32'h12345678, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                              32'hDEADBEEF, 32'h00000000, 32'hFFFF0000, 32'h80000001};
    logic [31:0] st_b [8] = '{32'h9ABCDEF0, 32'h00000001, 32'h7FFFFFFF, 32'h80000000,
                              32'h00010000, 32'hCAFEBABE, 32'h0000FFFF, 32'hFFFFFFFE};
    logic        st_s [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [31:0] bp_a [6] = '{32'h00000003, 32'hFFFFFFFE, 32'h0000ABCD, 32'h80000000,
                              32'h11111111, 32'h89ABCDEF};
    logic [31:0] bp_b [6] = '{32'h00000005, 32'h00000003, 32'h00001234, 32'hFFFFFFFF,
                              32'h00000010, 32'h76543210};
    logic        bp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic        use_s;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        use_s = s;
`ifndef MUL_PIPE_W_SIGNED_EN
        use_s = 1'b0;
`endif
        if (use_s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, then watch for its result: absent after 3 edges, present after 4.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input logic [3:0] tag, output logic lat_ok,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic [3:0] tag_out);
        logic v3;
        i_msg    = {b, a};
        i_signed = s;
        i_tag    = tag;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
        tick();
        tick();
        v3 = o_valid;
        tick();
        lat_ok  = !v3 && o_valid;
        hi      = o_hi;
        lo      = o_lo;
        tag_out = o_tag;
        tick();
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        i_valid  = 1'b0;
        i_msg    = '0;
        i_signed = 1'b0;
        i_tag    = '0;
        o_ready  = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_lo !== 32'h0 || o_hi !== 32'h0 || o_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b lo=%h hi=%h tag=%h, want 0/0/0/0",
                     o_valid, o_lo, o_hi, o_tag);
        end
        checks++;
        if (o_inflight !== 3'd0) begin
            errors++;
            $display("FAIL reset_inflight: got %0d, want 0", o_inflight);
        end
        tick();
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", i_ready);
        end
    endtask

    task automatic test_unsigned_max();
        logic lat_ok;
        logic [31:0] hi, lo;
        logic [3:0] t;
        issue_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h5, lat_ok, hi, lo, t);
        checks++;
        if (lat_ok !== 1'b1) begin
            errors++;
            $display("FAIL umax_latency: got %b, want 1", lat_ok);
        end
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || t !== 4'h5) begin
            errors++;
            $display("FAIL umax_result: got hi=%h lo=%h tag=%h, want fffffffe/00000001/5", hi, lo, t);
        end
    endtask

    task automatic test_signed();
        logic lat_ok;
        logic [31:0] hi, lo, exp_hi;
        logic [3:0] t;
`ifdef MUL_PIPE_W_SIGNED_EN
        exp_hi = 32'h00000000;
`else
        exp_hi = 32'hFFFFFFFE;
`endif
        issue_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'hA, lat_ok, hi, lo, t);
        checks++;
        if (hi !== exp_hi || lo !== 32'h00000001 || t !== 4'hA || lat_ok !== 1'b1) begin
            errors++;
            $display("FAIL signed_m1xm1: got hi=%h lo=%h tag=%h lat=%b, want %h/00000001/a/1",
                     hi, lo, t, lat_ok, exp_hi);
        end
    endtask

    task automatic test_mixed_sign();
        logic lat_ok;
        logic [31:0] hi, lo, exp_hi;
        logic [3:0] t;
`ifdef MUL_PIPE_W_SIGNED_EN
        exp_hi = 32'hFFFFFFFF;
`else
        exp_hi = 32'h00000001;
`endif
        issue_and_wait(32'h80000000, 32'h00000002, 1'b1, 4'h3, lat_ok, hi, lo, t);
        checks++;
        if (hi !== exp_hi || lo !== 32'h00000000 || t !== 4'h3) begin
            errors++;
            $display("FAIL mixed_signed: got hi=%h lo=%h tag=%h, want %h/00000000/3", hi, lo, t, exp_hi);
        end
        issue_and_wait(32'h80000000, 32'h00000002, 1'b0, 4'h4, lat_ok, hi, lo, t);
        checks++;
        if (hi !== 32'h00000001 || lo !== 32'h00000000 || t !== 4'h4) begin
            errors++;
            $display("FAIL mixed_unsigned: got hi=%h lo=%h tag=%h, want 00000001/00000000/4", hi, lo, t);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        for (int t = 1; t <= 11; t++) begin
            if (t <= 8) begin
                i_msg    = {st_b[t-1], st_a[t-1]};
                i_signed = st_s[t-1];
                i_tag    = 4'(t - 1);
                i_valid  = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (t >= 4) begin
                exp = model(st_a[t-4], st_b[t-4], st_s[t-4]);
                checks++;
                if (o_valid !== 1'b1 || o_tag !== 4'(t - 4) || {o_hi, o_lo} !== exp) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: got v=%b tag=%h prod=%h, want 1/%h/%h",
                             t - 4, o_valid, o_tag, {o_hi, o_lo}, 4'(t - 4), exp);
                end
            end
            if (t >= 4 && t <= 8) begin
                checks++;
                if (o_inflight !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b_inflight_t%0d: got %0d, want 4", t, o_inflight);
                end
            end
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_inflight !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drained: got v=%b inflight=%0d, want 0/0", o_valid, o_inflight);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int rcv;
        logic acc;
        logic [63:0] exp0;
        logic [63:0] exp;
        sent = 0;
        rcv  = 0;
        o_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_valid  = (sent < 6);
            i_msg    = {bp_b[sent % 6], bp_a[sent % 6]};
            i_signed = bp_s[sent % 6];
            i_tag    = 4'(8 + sent);
            acc = i_valid && i_ready;
            tick();
            if (acc) sent++;
        end
        o_ready = 1'b0;
        #1;
        exp0 = model(bp_a[0], bp_b[0], bp_s[0]);
        checks++;
        if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_inflight !== 3'd4) begin
            errors++;
            $display("FAIL bp_full: got v=%b rdy=%b inflight=%0d, want 1/0/4", o_valid, i_ready, o_inflight);
        end
        for (int c = 0; c < 3; c++) begin
            i_valid  = (sent < 6);
            i_msg    = {bp_b[sent % 6], bp_a[sent % 6]};
            i_signed = bp_s[sent % 6];
            i_tag    = 4'(8 + sent);
            acc = i_valid && i_ready;
            tick();
            if (acc) sent++;
            checks++;
            if (o_valid !== 1'b1 || o_tag !== 4'h8 || {o_hi, o_lo} !== exp0 || o_inflight !== 3'd4) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b tag=%h prod=%h inflight=%0d, want 1/8/%h/4",
                         c, o_valid, o_tag, {o_hi, o_lo}, o_inflight, exp0);
            end
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 1", i_ready);
        end
        for (int c = 0; c < 20 && rcv < 6; c++) begin
            i_valid  = (sent < 6);
            i_msg    = {bp_b[sent % 6], bp_a[sent % 6]};
            i_signed = bp_s[sent % 6];
            i_tag    = 4'(8 + sent);
            if (o_valid) begin
                exp = model(bp_a[rcv], bp_b[rcv], bp_s[rcv]);
                checks++;
                if (o_tag !== 4'(8 + rcv) || {o_hi, o_lo} !== exp) begin
                    errors++;
                    $display("FAIL bp_drain%0d: got tag=%h prod=%h, want %h/%h",
                             rcv, o_tag, {o_hi, o_lo}, 4'(8 + rcv), exp);
                end
                rcv++;
            end
            acc = i_valid && i_ready;
            tick();
            if (acc) sent++;
        end
        i_valid = 1'b0;
        checks++;
        if (rcv != 6 || sent != 6) begin
            errors++;
            $display("FAIL bp_count: got rcv=%0d sent=%0d, want 6/6", rcv, sent);
        end
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_inflight !== 3'd0) begin
            errors++;
            $display("FAIL bp_no_dup: got v=%b inflight=%0d, want 0/0", o_valid, o_inflight);
        end
    endtask

    task automatic test_reset_mid_stream();
        int stale;
        logic lat_ok;
        logic [31:0] hi, lo;
        logic [3:0] t;
        stale = 0;
        for (int c = 0; c < 3; c++) begin
            i_msg    = {32'h0000FFFF, 32'h00010001 + 32'(c)};
            i_signed = 1'b0;
            i_tag    = 4'(c);
            i_valid  = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        checks++;
        if (o_inflight !== 3'd3) begin
            errors++;
            $display("FAIL rst_pre_inflight: got %0d, want 3", o_inflight);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_inflight !== 3'd0 || o_lo !== 32'h0 || o_hi !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b inflight=%0d lo=%h hi=%h, want 0/0/0/0",
                     o_valid, o_inflight, o_lo, o_hi);
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale: got %0d valid cycles, want 0", stale);
        end
        issue_and_wait(32'h00000003, 32'h00000005, 1'b0, 4'hC, lat_ok, hi, lo, t);
        checks++;
        if (lat_ok !== 1'b1 || hi !== 32'h0 || lo !== 32'h0000000F || t !== 4'hC) begin
            errors++;
            $display("FAIL rst_after: got lat=%b hi=%h lo=%h tag=%h, want 1/00000000/0000000f/c",
                     lat_ok, hi, lo, t);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_mixed_sign();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
